// File: rtl/dm_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder_pkg
// Description : Shared widths, FSM state type and range helper for the
//               data-memory responder.
// Revision    : 1.0  initial release
// ============================================================================
package dm_responder_pkg;

  localparam int c_DM_AW = 14;   // CPU / loader word-address width
  localparam int c_DM_DW = 32;   // data word width

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,              // zero-fill sweep in progress
    ST_RUN  = 1'b1               // normal CPU / loader operation
  } dm_state_t;

  // True when a word address falls inside an array of 'depth' words.
  function automatic logic addr_in_range(input logic [c_DM_AW-1:0] a,
                                         input int unsigned         depth);
    return (32'(a) < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder_if
// Description : CPU data-memory port plus loader request channel.
//               master = CPU/loader side, slave = responder.
// Revision    : 1.0  initial release
// ============================================================================
interface dm_responder_if import dm_responder_pkg::*; ();

  logic               DM_WEB;
  logic [c_DM_DW-1:0] DM_BWEB;
  logic [c_DM_AW-1:0] DM_A;
  logic [c_DM_DW-1:0] DM_IN;
  logic [c_DM_DW-1:0] DM_OUT;
  logic               ld_valid;
  logic               ld_ready;
  logic [c_DM_AW-1:0] ld_addr;
  logic [c_DM_DW-1:0] ld_data;
  logic               init_done;
  logic               addr_err;

  modport master (
    output DM_WEB, DM_BWEB, DM_A, DM_IN, ld_valid, ld_addr, ld_data,
    input  DM_OUT, ld_ready, init_done, addr_err
  );

  modport slave (
    input  DM_WEB, DM_BWEB, DM_A, DM_IN, ld_valid, ld_addr, ld_data,
    output DM_OUT, ld_ready, init_done, addr_err
  );

endinterface
`default_nettype wire

// File: rtl/dm_bytemask_merge.sv
`default_nettype none
// ============================================================================
// Module      : dm_bytemask_merge
// Description : Combinational bit-masked merge. A 0 in i_bweb takes the
//               bit from i_new, a 1 keeps the bit from i_old.
// Revision    : 1.0  initial release
// ============================================================================
module dm_bytemask_merge import dm_responder_pkg::*; (
  input  wire logic [c_DM_DW-1:0] i_old,
  input  wire logic [c_DM_DW-1:0] i_new,
  input  wire logic [c_DM_DW-1:0] i_bweb,
  output logic      [c_DM_DW-1:0] o_merged
);

  assign o_merged = (i_old & i_bweb) | (i_new & ~i_bweb);

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Single-write-port data memory with bit-masked CPU writes,
//               1-cycle registered reads (write-first), a background loader
//               channel that yields to CPU writes, and an optional zero-fill
//               sweep after reset.
// Revision    : 1.0  initial release
// ============================================================================
module dm_responder import dm_responder_pkg::*; #(
  parameter int unsigned DEPTH      = 16384,  // at most 2**c_DM_AW words
  parameter bit          INIT_SWEEP = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dm_responder_if.slave bus
);

  localparam int unsigned c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CW = c_IW + 1;   // sweep counter must reach DEPTH
  localparam dm_state_t   c_RESET_ST = INIT_SWEEP ? ST_INIT : ST_RUN;

  logic [c_DM_DW-1:0] r_mem [DEPTH];
  dm_state_t          r_state;
  logic [c_CW-1:0]    r_sweep_cnt;
  logic [c_DM_DW-1:0] r_dout;
  logic               r_addr_err;
  logic               r_init_done;

  logic [c_IW-1:0]    w_cpu_idx;
  logic [c_IW-1:0]    w_ld_idx;
  logic               w_cpu_in;
  logic               w_ld_in;
  logic               w_run;
  logic               w_ld_ready;
  logic               w_cpu_wr;
  logic               w_ld_wr;
  logic               w_sweep_busy;
  logic [c_DM_DW-1:0] w_old;
  logic [c_DM_DW-1:0] w_merged;
  logic               w_we;
  logic [c_IW-1:0]    w_waddr;
  logic [c_DM_DW-1:0] w_wdata;
  logic [c_DM_DW-1:0] w_rd_next;

  assign w_run        = (r_state == ST_RUN);
  assign w_cpu_in     = addr_in_range(bus.DM_A, DEPTH);
  assign w_ld_in      = addr_in_range(bus.ld_addr, DEPTH);
  assign w_cpu_idx    = bus.DM_A[c_IW-1:0];
  assign w_ld_idx     = bus.ld_addr[c_IW-1:0];
  assign w_sweep_busy = (32'(r_sweep_cnt) < DEPTH);
  assign w_old        = r_mem[w_cpu_idx];

  // The loader only gets the port when the CPU is not writing.
  assign w_ld_ready = w_run && bus.DM_WEB;
  // Out-of-range requests are still handshaken but never reach the array.
  assign w_cpu_wr   = w_run && !bus.DM_WEB && w_cpu_in;
  assign w_ld_wr    = bus.ld_valid && w_ld_ready && w_ld_in;

  dm_bytemask_merge u_merge (
    .i_old    (w_old),
    .i_new    (bus.DM_IN),
    .i_bweb   (bus.DM_BWEB),
    .o_merged (w_merged)
  );

  // Single write port arbitration: sweep, then CPU, then loader.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst) begin
      if (!w_run) begin
        if (w_sweep_busy) begin
          w_we    = 1'b1;
          w_waddr = r_sweep_cnt[c_IW-1:0];
        end
      end else if (w_cpu_wr) begin
        w_we    = 1'b1;
        w_waddr = w_cpu_idx;
        w_wdata = w_merged;
      end else if (w_ld_wr) begin
        w_we    = 1'b1;
        w_waddr = w_ld_idx;
        w_wdata = bus.ld_data;
      end
    end
  end

  // Read data is whatever the array holds after this edge's write, so a
  // same-address CPU or loader write is forwarded straight to DM_OUT.
  always_comb begin
    w_rd_next = '0;
    if (w_cpu_in) begin
      w_rd_next = (w_we && (w_waddr == w_cpu_idx)) ? w_wdata : w_old;
    end
  end

  // Array storage; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Control FSM with registered read data, error pulse and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_RESET_ST;
      r_sweep_cnt <= '0;
      r_dout      <= '0;
      r_addr_err  <= 1'b0;
      r_init_done <= !INIT_SWEEP;
    end else if (r_state == ST_INIT) begin
      r_dout     <= '0;
      r_addr_err <= 1'b0;
      if (w_sweep_busy) begin
        r_sweep_cnt <= r_sweep_cnt + c_CW'(1);
      end else begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end else begin
      r_dout     <= w_rd_next;
      r_addr_err <= !w_cpu_in;
    end
  end

  assign bus.DM_OUT    = r_dout;
  assign bus.addr_err  = r_addr_err;
  assign bus.init_done = r_init_done;
  assign bus.ld_ready  = w_ld_ready;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder (DEPTH=16, sweep on),
//               directed corner cases plus randomized CPU/loader traffic
//               against a plain array model of the memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dm_responder;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] model [DEPTH];
  logic        ld_pend = 1'b0;

  always #5 clk = ~clk;

  dm_responder_if bus ();

  dm_responder #(.DEPTH(DEPTH), .INIT_SWEEP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic web, input logic [31:0] bweb, input int a,
                       input logic [31:0] din);
    bus.DM_WEB  = web;
    bus.DM_BWEB = bweb;
    bus.DM_A    = 14'(a);
    bus.DM_IN   = din;
  endtask

  // One RUN-mode cycle: check ld_ready before the edge, apply the memory
  // rules to the model at the edge, then compare registered outputs.
  task automatic step(output logic accepted);
    int          a;
    int          la;
    logic [31:0] exp_out;
    #2;
    chk("ld_ready", 32'(bus.ld_ready), 32'(bus.DM_WEB));
    @(posedge clk);
    a        = int'(bus.DM_A);
    la       = int'(bus.ld_addr);
    accepted = bus.ld_valid && bus.DM_WEB;
    if (!bus.DM_WEB) begin
      if (a < DEPTH)
        for (int i = 0; i < 32; i++)
          if (!bus.DM_BWEB[i]) model[a][i] = bus.DM_IN[i];
    end else if (accepted && la < DEPTH) begin
      model[la] = bus.ld_data;
    end
    exp_out = (a < DEPTH) ? model[a] : 32'h0;
    #1;
    chk("DM_OUT", bus.DM_OUT, exp_out);
    chk("addr_err", 32'(bus.addr_err), 32'(a >= DEPTH));
    chk("init_done", 32'(bus.init_done), 32'd1);
  endtask

  // Counts edges after rst release until init_done; CPU writes to addr 2
  // are attempted throughout and must be ignored.
  task automatic run_init(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      drive(k[0], 32'h0, 2, 32'hFFFF_FFFF);
      bus.ld_valid = 1'b0;
      #2;
      chk("init_ld_ready", 32'(bus.ld_ready), 32'd0);
      @(posedge clk);
      #1;
      cycles++;
      chk("init_DM_OUT", bus.DM_OUT, 32'h0);
      chk("init_addr_err", 32'(bus.addr_err), 32'd0);
      if (bus.init_done === 1'b1) break;
    end
    drive(1'b1, 32'hFFFF_FFFF, 0, 32'h0);
  endtask

  task automatic read_all_zero();
    logic acc;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 32'hFFFF_FFFF, a, 32'h0);
      step(acc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    logic        acc;
    logic [31:0] saved;

    drive(1'b1, 32'hFFFF_FFFF, 0, 32'h0);
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;

    // Reset state and sweep latency.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_DM_OUT", bus.DM_OUT, 32'h0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    rst = 1'b0;
    run_init(c);
    chk("init_latency", 32'(c), 32'd17);
    read_all_zero();

    // Bit-masked write.
    drive(1'b0, 32'h0, 3, 32'hFFFF_FFFF);               step(acc);
    drive(1'b0, 32'hFFFF_0000, 3, 32'h1234_5678);       step(acc);
    drive(1'b1, 32'hFFFF_FFFF, 3, 32'h0);               step(acc);
    chk("masked_write", bus.DM_OUT, 32'hFFFF_5678);

    // Write-first forwarding.
    drive(1'b0, 32'h0, 5, 32'hA5A5_A5A5);               step(acc);
    chk("write_first", bus.DM_OUT, 32'hA5A5_A5A5);

    // Loader stalled by CPU writes, then accepted with same-address read.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 14'd7;
    bus.ld_data  = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 10, 32'h1111_0000 + 32'(k));
      step(acc);
      chk("ld_stall", 32'(acc), 32'd0);
    end
    drive(1'b1, 32'hFFFF_FFFF, 7, 32'h0);               step(acc);
    chk("ld_accept", 32'(acc), 32'd1);
    chk("ld_bypass", bus.DM_OUT, 32'hCAFE_F00D);
    bus.ld_valid = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 7, 32'h0);               step(acc);
    chk("ld_readback", bus.DM_OUT, 32'hCAFE_F00D);

    // Out-of-range write must not alias onto address 4.
    saved = model[4];
    drive(1'b0, 32'h0, 20, 32'hDEAD_BEEF);              step(acc);
    chk("oor_err", 32'(bus.addr_err), 32'd1);
    drive(1'b1, 32'hFFFF_FFFF, 4, 32'h0);               step(acc);
    chk("oor_alias", bus.DM_OUT, saved);

    // Out-of-range loader transfer is dropped silently.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 14'd20;
    bus.ld_data  = 32'h5555_AAAA;
    drive(1'b1, 32'hFFFF_FFFF, 4, 32'h0);               step(acc);
    bus.ld_valid = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 4, 32'h0);               step(acc);

    // Randomized CPU and loader traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] bweb;
      case ($urandom_range(0, 3))
        0:       bweb = 32'h0;
        1:       bweb = 32'hFFFF_FFFF;
        default: bweb = $urandom;
      endcase
      drive(($urandom_range(0, 2) != 0), bweb, int'($urandom_range(0, 19)), $urandom);
      if (!ld_pend && $urandom_range(0, 2) == 0) begin
        ld_pend      = 1'b1;
        bus.ld_addr  = 14'($urandom_range(0, 19));
        bus.ld_data  = $urandom;
      end
      bus.ld_valid = ld_pend;
      step(acc);
      if (acc) ld_pend = 1'b0;
    end
    bus.ld_valid = 1'b0;

    // Reset in the middle of the sweep, at sweep address 9.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_init_done", 32'(bus.init_done), 32'd0);
    chk("rst2_DM_OUT", bus.DM_OUT, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      chk("sweep1_init_done", 32'(bus.init_done), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_init(c);
    chk("restart_latency", 32'(c), 32'd17);
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
